// File: rtl/wb_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_queue_pkg                                              |
// | Purpose  : Shared widths, the PC register address and the retire     |
// |            classification used by the writeback queue.               |
// | Contents : FULLW    - datapath word width                            |
// |            PC_ADDR  - register index that aliases the PC (r15)       |
// |            ret_kind_e / classify_retire - what the head does now     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package wb_queue_pkg;

   localparam int FULLW   = 32;
   localparam int PC_ADDR = 15;

   typedef enum logic [1:0] {
      RET_NONE = 2'd0,
      RET_REG  = 2'd1,
      RET_PC   = 2'd2
   } ret_kind_e;

   // A popped head goes either to the register file or to the PC port.
   function automatic ret_kind_e classify_retire(input logic pop, input logic is_pc);
      if (!pop)
         return RET_NONE;
      else if (is_pc)
         return RET_PC;
      else
         return RET_REG;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_queue_if                                               |
// | Purpose  : Producer/retire bundle of the writeback queue.            |
// | Ports    : ld_*  / alu_*  - load and ALU results (load is older)     |
// |            in_ready       - at least two free entries                |
// |            drain_en       - retire permission                        |
// |            we/wa/wd       - register-file write port                 |
// |            pc_we/pc_wd    - PC load port                             |
// |            master: producer/consumer side, slave: the queue          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface wb_queue_if #(
   parameter int ADDR_WIDTH = 4
);
   import wb_queue_pkg::*;

   logic                  ld_valid;
   logic [ADDR_WIDTH-1:0] ld_wa;
   logic [FULLW-1:0]      ld_wd;
   logic                  alu_valid;
   logic [ADDR_WIDTH-1:0] alu_wa;
   logic [FULLW-1:0]      alu_wd;
   logic                  in_ready;
   logic                  drain_en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [FULLW-1:0]      wd;
   logic                  pc_we;
   logic [FULLW-1:0]      pc_wd;

   modport master (
      output ld_valid, ld_wa, ld_wd, alu_valid, alu_wa, alu_wd, drain_en,
      input  in_ready, we, wa, wd, pc_we, pc_wd
   );

   modport slave (
      input  ld_valid, ld_wa, ld_wd, alu_valid, alu_wa, alu_wd, drain_en,
      output in_ready, we, wa, wd, pc_we, pc_wd
   );

endinterface
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_fwd_match                                              |
// | Purpose  : Youngest-first match of one read address against the      |
// |            queue entries.                                            |
// | Ports    : addr            - decode read address                     |
// |            ent_wa/ent_wd   - entry array contents                    |
// |            ent_vld         - entry valid mask                        |
// |            head            - index of the oldest entry               |
// |            hit/fwd         - newest pending value (0 on a miss)      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_fwd_match
   import wb_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_wa,
   input  logic [DEPTH-1:0][FULLW-1:0]      ent_wd,
   input  logic [DEPTH-1:0]                 ent_vld,
   input  logic [$clog2(DEPTH)-1:0]         head,
   output logic                             hit,
   output logic [FULLW-1:0]                 fwd
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   // Walk from the head (oldest) towards the tail; each later match
   // overrides the earlier one, so the youngest pending write wins.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (ent_vld[idx] && (ent_wa[idx] == addr)) begin
            hit = 1'b1;
            fwd = ent_wd[idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_queue                                                  |
// | Purpose  : Writeback queue in front of the single register-file      |
// |            write port. Takes up to two results per cycle, retires    |
// |            one per cycle, diverts r15 writes to the PC port and      |
// |            forwards pending values to the decode read ports.         |
// | Ports    : clk, rst        - clock, async active-high reset          |
// |            bus (slave)     - enqueue and retire signals              |
// |            rn_a/rm_a       - decode read addresses                   |
// |            rn_*/rm_* hit/fwd - forwarded pending values              |
// |            count           - occupancy                               |
// |            ovf             - sticky: an enqueue was dropped          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   wb_queue_if.slave                bus,
   input  logic [ADDR_WIDTH-1:0]    rn_a,
   input  logic [ADDR_WIDTH-1:0]    rm_a,
   output logic                     rn_hit,
   output logic                     rm_hit,
   output logic [FULLW-1:0]         rn_fwd,
   output logic [FULLW-1:0]         rm_fwd,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][ADDR_WIDTH-1:0] wa_q, wa_d;
   logic [DEPTH-1:0][FULLW-1:0]      wd_q, wd_d;
   logic [DEPTH-1:0]                 vld_q, vld_d;
   logic [PTR_W-1:0]                 head_q, head_d;
   logic [PTR_W-1:0]                 tail_q, tail_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic                             ovf_q, ovf_d;

   logic [CNT_W-1:0] free;
   logic             acc_ld;
   logic             acc_alu;
   logic             pop;
   logic [PTR_W-1:0] alu_slot;
   ret_kind_e        kind;

   // Free space is judged on pre-edge occupancy: a retire in the same
   // cycle does not make room. With one slot left the load (older) wins.
   always_comb begin
      free     = CNT_W'(DEPTH) - count_q;
      acc_ld   = bus.ld_valid && (free != '0);
      acc_alu  = bus.alu_valid && (free > CNT_W'(acc_ld));
      pop      = (count_q != '0) && bus.drain_en;
      alu_slot = tail_q + PTR_W'(acc_ld);

      wa_d    = wa_q;
      wd_d    = wd_q;
      vld_d   = vld_q;
      head_d  = head_q;
      tail_d  = tail_q + PTR_W'(acc_ld) + PTR_W'(acc_alu);
      count_d = count_q + CNT_W'(acc_ld) + CNT_W'(acc_alu) - CNT_W'(pop);
      ovf_d   = ovf_q | (bus.ld_valid & ~acc_ld) | (bus.alu_valid & ~acc_alu);

      // Enqueue slots are always free slots, so they never collide with
      // the head being popped.
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PTR_W'(1);
      end
      if (acc_ld) begin
         wa_d[tail_q]  = bus.ld_wa;
         wd_d[tail_q]  = bus.ld_wd;
         vld_d[tail_q] = 1'b1;
      end
      if (acc_alu) begin
         wa_d[alu_slot]  = bus.alu_wa;
         wd_d[alu_slot]  = bus.alu_wd;
         vld_d[alu_slot] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wa_q    <= '0;
         wd_q    <= '0;
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Retire port is combinational from the head entry; entries reset to
   // zero so wa/wd read zero straight out of reset.
   assign kind         = classify_retire(pop, wa_q[head_q] == ADDR_WIDTH'(PC_ADDR));
   assign bus.we       = (kind == RET_REG);
   assign bus.pc_we    = (kind == RET_PC);
   assign bus.wa       = wa_q[head_q];
   assign bus.wd       = wd_q[head_q];
   assign bus.pc_wd    = wd_q[head_q];
   assign bus.in_ready = (free >= CNT_W'(2));
   assign count        = count_q;
   assign ovf          = ovf_q;

   wb_fwd_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_rn_match (
      .addr    (rn_a),
      .ent_wa  (wa_q),
      .ent_wd  (wd_q),
      .ent_vld (vld_q),
      .head    (head_q),
      .hit     (rn_hit),
      .fwd     (rn_fwd)
   );

   wb_fwd_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_rm_match (
      .addr    (rm_a),
      .ent_wa  (wa_q),
      .ent_wd  (wd_q),
      .ent_vld (vld_q),
      .head    (head_q),
      .hit     (rm_hit),
      .fwd     (rm_fwd)
   );

endmodule
`default_nettype wire

// File: doc/wb_queue.md
# wb_queue

Writeback queue feeding the register file's single write port. Accepts results from the ALU and the load path (up to two per cycle), retires one per cycle into the register file as `we`/`wa`/`wd`, and redirects writes to r15 onto a PC-load output instead of the file. Also forwards pending, not-yet-retired values to the decode-stage register read ports.

## Interface
- `ADDR_WIDTH`, 4: register address width; r15 (`PC_ADDR`) is the PC.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  load result valid.
- `ld_wa`  in  ADDR_WIDTH  load destination register.
- `ld_wd`  in  `FULLW`  load data.
- `alu_valid`  in  1  ALU result valid.
- `alu_wa`  in  ADDR_WIDTH  ALU destination register.
- `alu_wd`  in  `FULLW`  ALU data.
- `in_ready`  out  1  at least 2 free entries; producers may assert valid only when high.
- `drain_en`  in  1  retire permission this cycle.
- `we`  out  1  register-file write enable.
- `wa`  out  ADDR_WIDTH  register-file write address.
- `wd`  out  `FULLW`  register-file write data.
- `pc_we`  out  1  PC load strobe (head targets r15).
- `pc_wd`  out  `FULLW`  PC load value.
- `rn_a`, `rm_a`  in  ADDR_WIDTH  decode read addresses.
- `rn_hit`, `rm_hit`  out  1  pending write exists for the address.
- `rn_fwd`, `rm_fwd`  out  `FULLW`  newest pending value for the address.
- `count`  out  clog2(DEPTH)+1  occupancy.
- `ovf`  out  1  sticky: an enqueue was dropped.

## Operation
- Circular buffer: `head`, `tail` pointers, occupancy counter; each entry holds {wa, wd}.
- Enqueue order in the same cycle: load first (older), then ALU. Each valid source takes the next tail slot.
- Enqueue arriving while free slots are fewer than needed: the excess source is dropped (ALU dropped before load) and `ovf` sets. `ovf` clears only on reset.
- Retire: when `count != 0` and `drain_en`, pop the head. If head wa == `PC_ADDR`, assert `pc_we`/`pc_wd`, keep `we` low. Otherwise assert `we`, `wa`, `wd`.
- `we`, `wa`, `wd`, `pc_we`, and `pc_wd` are combinational from the head entry. When not retiring, `we` and `pc_we` are 0; `wa` and `wd` still show head contents.
- Forwarding: compare `rn_a`/`rm_a` against all valid entries, including the head being retired this cycle. Return the youngest match; a miss returns hit=0 and fwd=0.
- Same-cycle inputs (`ld_*`, `alu_*`) are never forwarded; the hazard unit stalls for them.
- r15 entries also participate in forwarding.

## Timing
- A result enqueued at edge N is at the earliest retired at edge N+1, and the register file holds it from N+1. Forwarding covers it from after edge N until it retires.
- Register-file reads are synchronous. A read sampled at the retiring edge sees the old file value, so the head must be forwarded in that cycle.
- Simultaneous enqueue and retire: occupancy changes by (enqueued − 1). Free-slot checks use pre-edge occupancy, so a retire does not free a slot for the same edge.
- `in_ready` = (DEPTH − count) ≥ 2, combinational from `count`.
- Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time including mid-retire): pointers = 0, `count` = 0, `ovf` = 0, and all entries invalid. Outputs go to `we` = 0, `pc_we` = 0, `wa` = 0, `wd` = 0, `pc_wd` = 0, hits = 0, fwd = 0, `in_ready` = 1. In-flight entries are discarded.

## Structure
- `PC_ADDR` (4'd15) is added to `defines.v` next to `FULLW`, `WIDTH`, and `WORD`.
- Sub-module `wb_fwd_match` implements the youngest-first priority match of one address against the entry array (valid mask, head pointer). It is instantiated twice, for rn and rm.

## Test plan
- Reset, then `ld_valid` with wa=3, wd=0xDEADBEEF. Next cycle with `drain_en`=1 → `we`=1, `wa`=3, `wd`=0xDEADBEEF; `count` goes 1 → 0.
- Same-cycle load (wa=5, 0x11) and ALU (wa=5, 0x22) with `drain_en`=0. `rn_a`=5 → `rn_hit`=1, `rn_fwd`=0x22. Draining retires 0x11 first, then 0x22.
- Enqueue wa=15, wd=0x100 and drain → `pc_we`=1, `pc_wd`=0x100, `we`=0.
- Fill to DEPTH−1 → `in_ready`=0. Forcing both valids → load accepted, ALU dropped, `ovf`=1, `count`=DEPTH.
- Run 2*DEPTH+1 enqueue/retire pairs → pointers wrap and data is retired in order.
- Assert `rst` mid-stream with `count`=3 → all outputs return to reset values immediately, without a clock edge.
